// File: rtl/sm4_pkg.sv
// Shared SM4 constants and helpers: FK words, S-box, CK generator, key-schedule linear transform, FSM states.
package sm4_pkg;

  localparam int NUM_ROUNDS = 32;
  localparam int IDX_W      = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

  localparam logic [0:3][31:0] FK = {32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  typedef enum logic [1:0] {IDLE, RUN, GEN, DONE} state_e;

  // Byte j of CK_i is (4*i+j)*7 mod 256, most significant byte first.
  function automatic logic [31:0] ck_of(input logic [IDX_W-1:0] round);
    logic [31:0] ck;
    ck = '0;
    for (int j = 0; j < 4; j++) begin
      ck = {ck[23:0], 8'({1'b0, round, 2'(j)} * 8'd7)};
    end
    return ck;
  endfunction

  function automatic logic [31:0] l_key(input logic [31:0] b);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

endpackage

// File: rtl/sm4_tau.sv
// SM4 non-linear substitution: four parallel S-box lookups on a 32-bit word.
module sm4_tau
  import sm4_pkg::*;
(
  input  logic [31:0] a_i,
  output logic [31:0] b_o
);

  assign b_o = {SBOX[a_i[31:24]], SBOX[a_i[23:16]], SBOX[a_i[15:8]], SBOX[a_i[7:0]]};

endmodule

// File: rtl/sm4_key_expand.sv
// SM4 key schedule: expands a 128-bit master key into rk0..rk31 on a valid/ready stream.
// Defining SM4_KEY_REVERSE_EN adds a dec input and a key buffer so keys can be streamed rk31..rk0.
module sm4_key_expand
  import sm4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     mkey,
`ifdef SM4_KEY_REVERSE_EN
  input  logic             dec,
`endif
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [31:0]      rk,
  output logic [IDX_W-1:0] rk_idx,
  output logic             done
);

  state_e           state_q, state_d;
  logic [3:0][31:0] k_q, k_d;
  logic [IDX_W-1:0] round_q, round_d;
  logic             rk_valid_q, rk_valid_d;
  logic [31:0]      rk_q, rk_d;
  logic [IDX_W-1:0] rk_idx_q, rk_idx_d;
  logic [31:0]      tau_in, tau_out, new_key;
  logic [IDX_W-1:0] last_idx;

  assign tau_in = k_q[1] ^ k_q[2] ^ k_q[3] ^ ck_of(round_q);

  sm4_tau u_tau (
    .a_i (tau_in),
    .b_o (tau_out)
  );

  assign new_key = k_q[0] ^ l_key(tau_out);

`ifdef SM4_KEY_REVERSE_EN
  logic        dec_q, dec_d;
  logic [31:0] kbuf_q [NUM_ROUNDS];

  // NOTE: the key buffer has no reset; every entry is rewritten in GEN before RUN reads it.
  always_ff @(posedge clk) begin
    if (state_q == GEN) kbuf_q[round_q] <= new_key;
  end

  assign last_idx = dec_q ? '0 : LAST_IDX;
`else
  assign last_idx = LAST_IDX;
`endif

  always_comb begin
    // NOTE: every _d starts from its _q, so branches that leave it alone hold state instead of inferring a latch.
    state_d    = state_q;
    k_d        = k_q;
    round_d    = round_q;
    rk_valid_d = rk_valid_q;
    rk_d       = rk_q;
    rk_idx_d   = rk_idx_q;
`ifdef SM4_KEY_REVERSE_EN
    dec_d      = dec_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int j = 0; j < 4; j++) k_d[j] = mkey[127-32*j -: 32] ^ FK[j];
          round_d = '0;
          state_d = RUN;
`ifdef SM4_KEY_REVERSE_EN
          dec_d = dec;
          if (dec) state_d = GEN;
`endif
        end
      end
      RUN: begin
        if (rk_valid_q && rk_ready && (rk_idx_q == last_idx)) begin
          rk_valid_d = 1'b0;
          state_d    = DONE;
        end else if (!rk_valid_q || rk_ready) begin
          rk_valid_d = 1'b1;
          rk_idx_d   = round_q;
          k_d        = {new_key, k_q[3:1]};
          rk_d       = new_key;
          round_d    = round_q + IDX_W'(1);
`ifdef SM4_KEY_REVERSE_EN
          if (dec_q) begin
            k_d     = k_q;
            rk_d    = kbuf_q[round_q];
            round_d = round_q - IDX_W'(1);
          end
`endif
        end
      end
`ifdef SM4_KEY_REVERSE_EN
      GEN: begin
        k_d     = {new_key, k_q[3:1]};
        round_d = round_q + IDX_W'(1);
        // The final generated key is presented directly so streaming starts without a bubble.
        if (round_q == LAST_IDX) begin
          state_d    = RUN;
          rk_valid_d = 1'b1;
          rk_d       = new_key;
          rk_idx_d   = LAST_IDX;
          round_d    = round_q - IDX_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      round_q    <= '0;
      rk_valid_q <= 1'b0;
      rk_q       <= '0;
      rk_idx_q   <= '0;
`ifdef SM4_KEY_REVERSE_EN
      dec_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      round_q    <= round_d;
      rk_valid_q <= rk_valid_d;
      rk_q       <= rk_d;
      rk_idx_q   <= rk_idx_d;
`ifdef SM4_KEY_REVERSE_EN
      dec_q      <= dec_d;
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign rk_valid = rk_valid_q;
  assign rk       = rk_q;
  assign rk_idx   = rk_idx_q;
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_sm4_key_expand.sv
// Self-checking bench for sm4_key_expand: standard vector, backpressure, ignored start, reset abort, random keys.
`timescale 1ns/1ps
module tb_sm4_key_expand;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         rk_ready = 1'b0;
  logic [127:0] mkey = '0;
`ifdef SM4_KEY_REVERSE_EN
  logic         dec = 1'b0;
`endif
  logic         busy, rk_valid, done;
  logic [31:0]  rk;
  logic [4:0]   rk_idx;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_rk [32];
  logic [31:0] got_rk [$];
  int          got_idx [$];
  int          got_cyc [$];
  int          done_cyc;
  bit          reset_hit;

  localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] FK_ALL  = 128'ha3b1bac656aa3350677d9197b27022dc;

  always #5 clk = ~clk;

  sm4_key_expand dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mkey     (mkey),
`ifdef SM4_KEY_REVERSE_EN
    .dec      (dec),
`endif
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk       (rk),
    .rk_idx   (rk_idx),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_tau(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int b = 0; b < 4; b++) y[8*b +: 8] = sm4_pkg::SBOX[x[8*b +: 8]];
    return y;
  endfunction

  task automatic compute_ref(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] ck, t;
    for (int j = 0; j < 4; j++) k[j] = mk[127-32*j -: 32] ^ FK_ALL[127-32*j -: 32];
    for (int i = 0; i < 32; i++) begin
      ck = '0;
      for (int j = 0; j < 4; j++) ck = {ck[23:0], 8'((4*i + j) * 7)};
      t = m_tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ t ^ {t[18:0], t[31:19]} ^ {t[8:0], t[31:9]};
      ref_rk[i] = k[i+4];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},     32'(busy),     32'd0);
    check({tag, " rk_valid"}, 32'(rk_valid), 32'd0);
    check({tag, " rk"},       rk,            32'd0);
    check({tag, " rk_idx"},   32'(rk_idx),   32'd0);
    check({tag, " done"},     32'(done),     32'd0);
  endtask

  // Starts a run and consumes keys until done; optional stall, stray start, or reset at a given index.
  task automatic run_stream(input logic [127:0] mk, input int stall_at, input int poke_at, input int rst_at);
    int cyc = 0;
    int stall_left = 5;
    bit post_checked = 1'b0;
    bit poked = 1'b0;
    got_rk.delete();
    got_idx.delete();
    got_cyc.delete();
    done_cyc  = -1;
    reset_hit = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    mkey     = mk;
    rk_ready = 1'b1;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      rk_ready = 1'b1;
      if (rk_valid && rst_at >= 0 && int'(rk_idx) == rst_at) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("async reset");
        reset_hit = 1'b1;
        break;
      end
      if (rk_valid && stall_at >= 0 && int'(rk_idx) == stall_at) begin
        if (stall_left < 5 || (stall_left == 0 && !post_checked)) begin
          check("stall rk",       rk,            ref_rk[stall_at]);
          check("stall rk_idx",   32'(rk_idx),   32'(stall_at));
          check("stall rk_valid", 32'(rk_valid), 32'd1);
          if (stall_left == 0) post_checked = 1'b1;
        end
        if (stall_left > 0) begin
          rk_ready = 1'b0;
          stall_left--;
        end
      end
      if (rk_valid && poke_at >= 0 && int'(rk_idx) == poke_at && !poked) begin
        start = 1'b1;
        mkey  = ~mk;
        poked = 1'b1;
      end
      if (rk_valid && rk_ready) begin
        got_rk.push_back(rk);
        got_idx.push_back(int'(rk_idx));
        got_cyc.push_back(cyc);
      end
    end
    if (!reset_hit && done_cyc < 0) check("done timeout", 32'd0, 32'd1);
  endtask

  task automatic compare_stream(input string name, input bit reverse);
    int e;
    check({name, " count"}, 32'(got_rk.size()), 32'd32);
    for (int i = 0; i < got_rk.size() && i < 32; i++) begin
      e = reverse ? 31 - i : i;
      check($sformatf("%s idx%0d", name, i), 32'(got_idx[i]), 32'(e));
      check($sformatf("%s rk%0d", name, i), got_rk[i], ref_rk[e]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    check("ck0",  sm4_pkg::ck_of(5'd0),  32'h00070e15);
    check("ck31", sm4_pkg::ck_of(5'd31), 32'h646b7279);
    rst = 1'b0;
    @(negedge clk);

    // Standard vector, free-running consumer.
    compute_ref(STD_KEY);
    run_stream(STD_KEY, -1, -1, -1);
    compare_stream("std", 1'b0);
    check("std rk0",  got_rk.size() > 0  ? got_rk[0]  : 32'd0, 32'hf12186f9);
    check("std rk1",  got_rk.size() > 1  ? got_rk[1]  : 32'd0, 32'h41662b61);
    check("std rk31", got_rk.size() > 31 ? got_rk[31] : 32'd0, 32'h9124a012);
    check("std first cycle", 32'(got_cyc.size() > 0  ? got_cyc[0]  : -1), 32'd2);
    check("std last cycle",  32'(got_cyc.size() > 31 ? got_cyc[31] : -1), 32'd33);
    check("std done cycle",  32'(done_cyc), 32'd34);
    check("std done busy",   32'(busy), 32'd1);
    // start during the DONE cycle must be ignored.
    start = 1'b1;
    mkey  = '0;
    @(negedge clk);
    start = 1'b0;
    check("done one cycle",   32'(done),     32'd0);
    check("start in done",    32'(busy),     32'd0);
    check("idle no valid",    32'(rk_valid), 32'd0);

    // Backpressure at index 7.
    run_stream(STD_KEY, 7, -1, -1);
    compare_stream("stall", 1'b0);

    // Stray start with a different key while busy.
    run_stream(STD_KEY, -1, 10, -1);
    compare_stream("poke", 1'b0);
    compute_ref('0);
    run_stream('0, -1, -1, -1);
    compare_stream("zero", 1'b0);

    // Reset at index 15, then a clean restart.
    compute_ref(STD_KEY);
    run_stream(STD_KEY, -1, -1, 15);
    check("reset reached", 32'(reset_hit), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("post-reset valid c%0d", c), 32'(rk_valid), 32'd0);
      check($sformatf("post-reset busy c%0d", c),  32'(busy),     32'd0);
    end
    run_stream(STD_KEY, -1, -1, -1);
    compare_stream("restart", 1'b0);

    // Random master keys.
    for (int r = 0; r < 20; r++) begin
      logic [127:0] mk;
      mk = {$urandom(), $urandom(), $urandom(), $urandom()};
      compute_ref(mk);
      run_stream(mk, (r % 4 == 0) ? int'($urandom_range(0, 31)) : -1, -1, -1);
      compare_stream($sformatf("rand%0d", r), 1'b0);
    end

`ifdef SM4_KEY_REVERSE_EN
    compute_ref(STD_KEY);
    dec = 1'b1;
    run_stream(STD_KEY, 20, -1, -1);
    dec = 1'b0;
    compare_stream("rev", 1'b1);
    check("rev first rk",    got_rk.size() > 0  ? got_rk[0]  : 32'd0, 32'h9124a012);
    check("rev last rk",     got_rk.size() > 31 ? got_rk[31] : 32'd0, 32'hf12186f9);
    check("rev first cycle", 32'(got_cyc.size() > 0 ? got_cyc[0] : -1), 32'd33);
    @(negedge clk);
    compute_ref(STD_KEY);
    run_stream(STD_KEY, -1, -1, -1);
    compare_stream("fwd after rev", 1'b0);
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
